// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux: scans NDIG double-buffered BCD digits onto one shared BCD bus.
// The block drives active-low anode enables in step with that bus, with a
// one-cycle dead time between digit slots.
// New digit values move from the shadow buffer into the active buffer only at
// frame boundaries.
// Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, digits above
// the most significant nonzero digit are kept dark.
module bcd_scan_mux #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned PRESCALE = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits_in,
  output logic [3:0]        bcd_out,
  output logic [NDIG-1:0]   an_n,
  output logic              frame_done,
  output logic              pending
);

  localparam int unsigned PW = $clog2(PRESCALE);
  localparam int unsigned IW = $clog2(NDIG);

  logic [PW-1:0]      r_presc;
  logic [IW-1:0]      r_idx;
  logic [4*NDIG-1:0]  r_active;
  logic [4*NDIG-1:0]  r_shadow;
  logic               r_pending;
  logic [3:0]         r_bcd;
  logic [NDIG-1:0]    r_an_n;
  logic               r_frame_done;

  logic               w_tick;
  logic               w_wrap;
  logic [3:0]         w_cur_digit;
  logic [NDIG-1:0]    w_lit_an;
  logic               w_dark;

  assign w_tick   = (r_presc == PW'(PRESCALE - 1));
  assign w_wrap   = w_tick && (r_idx == IW'(NDIG - 1));
  assign w_lit_an = ~(NDIG'(1) << r_idx);

  // Select the active-buffer nibble for the digit currently being scanned.
  always_comb begin
    w_cur_digit = 4'h0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (IW'(i) == r_idx) w_cur_digit = r_active[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0]   r_blank;
  logic [NDIG-1:0]   w_blank_next;
  logic [4*NDIG-1:0] w_active_next;
  logic              w_seen;

  assign w_active_next = (w_wrap && r_pending) ? r_shadow : r_active;

  // Blank mask from the buffer that becomes active at this boundary.
  // Walk from the top digit down; stop blanking at the first nonzero digit.
  // Digit 0 is never blanked.
  always_comb begin
    w_blank_next = '0;
    w_seen       = 1'b0;
    for (int unsigned k = 0; k < NDIG - 1; k++) begin
      if (w_active_next[4*(NDIG-1-k) +: 4] != 4'h0) w_seen = 1'b1;
      w_blank_next[NDIG-1-k] = !w_seen;
    end
  end

  // Blank mask register, refreshed at each frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_blank <= '0;
    else if (w_wrap) r_blank <= w_blank_next;
  end

  assign w_dark = r_blank[r_idx];
`else
  assign w_dark = 1'b0;
`endif

  // Prescaler and digit index; the index advances on each tick and wraps per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= w_wrap ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Double buffer. A load in the boundary cycle still lets the old shadow through
  // to the active buffer. The freshly loaded data then stays pending for one more frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wrap && r_pending) r_active <= r_shadow;
      if (load) begin
        r_shadow  <= digits_in;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Registered display outputs. The tick cycle forces a one-cycle anode dead time,
  // and the BCD bus holds its value during that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd        <= 4'h0;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_an_n <= '1;
      end else begin
        r_bcd  <= w_cur_digit;
        r_an_n <= w_dark ? '1 : w_lit_an;
      end
    end
  end

  assign bcd_out    = r_bcd;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Scoreboard bench for bcd_scan_mux.
// The driver predicts every post-edge output from frame arithmetic
// (edge number -> frame position -> slot/phase). It pushes each prediction into
// a queue. The monitor pops and compares once per falling edge.
module tb_bcd_scan_mux;
  localparam int unsigned NDIG  = 4;
  localparam int unsigned PS    = 4;
  localparam int unsigned DW    = 4 * NDIG;
  localparam int unsigned FRAME = PS * NDIG;

  typedef struct packed {
    logic [3:0]      bcd;
    logic [NDIG-1:0] an;
    logic            fd;
    logic            pend;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [DW-1:0]   digits_in;
  logic [3:0]      bcd_out;
  logic [NDIG-1:0] an_n;
  logic            frame_done;
  logic            pending;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned pushed = 0;
  int unsigned popped = 0;
  exp_t        expq[$];

  // reference state
  int unsigned n;
  logic [3:0]  m_active[NDIG];
  logic [3:0]  m_shadow[NDIG];
  bit          m_blank[NDIG];
  bit          m_pend;
  logic [3:0]  m_bcd;

  bcd_scan_mux #(.NDIG(NDIG), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in),
    .bcd_out(bcd_out), .an_n(an_n), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_pend = 1'b0;
    m_bcd  = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      m_active[i] = 4'h0;
      m_shadow[i] = 4'h0;
      m_blank[i]  = 1'b0;
    end
  endtask

  // Apply inputs for one cycle, predict the outputs after the next rising edge, and queue them.
  task automatic step(input bit ld, input logic [DW-1:0] din);
    exp_t        e;
    int unsigned pos, slot, ph;
    int          hi;
    bit          bnd;
    load      = ld;
    digits_in = din;
    @(posedge clk);
    pos  = n % FRAME;
    slot = pos / PS;
    ph   = pos % PS;
    bnd  = (pos == FRAME - 1);
    e.fd = bnd;
    if (ph == PS - 1) begin
      e.an  = '1;
      e.bcd = m_bcd;
    end else begin
      e.bcd = m_active[slot];
      e.an  = m_blank[slot] ? {NDIG{1'b1}} : ~(NDIG'(1) << slot);
      m_bcd = e.bcd;
    end
    if (bnd && m_pend) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (bnd) begin
      hi = 0;
      for (int i = 0; i < NDIG; i++) if (m_active[i] != 4'h0) hi = i;
      for (int i = 0; i < NDIG; i++) m_blank[i] = (i > hi);
    end
`endif
    if (ld) begin
      for (int i = 0; i < NDIG; i++) m_shadow[i] = din[4*i +: 4];
      m_pend = 1'b1;
    end
    e.pend = m_pend;
    expq.push_back(e);
    pushed++;
    n++;
    #1;
  endtask

  task automatic idle(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step(1'b0, '0);
  endtask

  task automatic align(input int unsigned p);
    while ((n % FRAME) != p) step(1'b0, '0);
  endtask

  // monitor: compare DUT outputs against queued predictions
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        popped++;
        total++;
        if ({bcd_out, an_n, frame_done, pending} !== e) begin
          bad++;
          $display("FAIL scan edge#%0d: got bcd=%h an=%b fd=%b pend=%b required bcd=%h an=%b fd=%b pend=%b",
                   popped, bcd_out, an_n, frame_done, pending, e.bcd, e.an, e.fd, e.pend);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1; load = 1'b0; digits_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_an", 32'(an_n), 32'hF);
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    chk("reset_fd", 32'(frame_done), 32'h0);
    chk("reset_pend", 32'(pending), 32'h0);
    rst = 1'b0;
    model_reset();

    // idle scan, blank digits
    idle(40);
    // mid-frame load
    align(5);
    step(1'b1, 16'h1234);
    idle(40);
    // two loads within one frame, last wins
    align(2);
    step(1'b1, 16'h1111);
    idle(3);
    step(1'b1, 16'h2222);
    idle(40);
    // load in the exact boundary cycle while another value is pending
    align(2);
    step(1'b1, 16'h1234);
    align(FRAME - 1);
    step(1'b1, 16'h5678);
    idle(48);
    // leading zeros, then all zero
    step(1'b1, 16'h0070);
    idle(40);
    step(1'b1, 16'h0000);
    idle(40);
    // randomized loads, including non-decimal nibbles
    for (int i = 0; i < 300; i++) begin
      d = DW'($urandom);
      step($urandom_range(0, 5) == 0, d);
    end
    // asynchronous reset mid-slot with a load pending
    align(6);
    step(1'b1, 16'h9876);
    idle(2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_an", 32'(an_n), 32'hF);
    chk("async_bcd", 32'(bcd_out), 32'h0);
    chk("async_fd", 32'(frame_done), 32'h0);
    chk("async_pend", 32'(pending), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    idle(40);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    chk("pop_count", popped, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
Upstream stage of the BCD-to-7-segment decoder in the multiplexed display path. Holds NDIG BCD digits and time-multiplexes them onto one shared 4-bit BCD bus that feeds the decoder. Drives active-low digit anode enables in step with that bus. New display values load through a double buffer and are applied only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NDIG, 4, number of digits scanned; legal range 2..8.
PRESCALE, 50000, clk cycles per digit slot; must be >= 3.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
load  in  1  single-cycle strobe; captures digits_in.
digits_in  in  4*NDIG  packed BCD digits; digit 0 in [3:0] (least significant).
bcd_out  out  4  BCD nibble of the currently displayed digit; goes to the decoder input.
an_n  out  NDIG  active-low anode enables, one-hot-low or all-high.
frame_done  out  1  one-cycle pulse when the scan wraps from digit NDIG-1 to digit 0.
pending  out  1  high while loaded data waits for a frame boundary.

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, idx=0.
  - active buffer=0, shadow buffer=0, pending=0.
  - bcd_out=4'h0, an_n=all ones, frame_done=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle where the count equals PRESCALE-1.
- Digit index:
  - On tick, idx increments.
  - idx wraps from NDIG-1 to 0.
  - The tick that wraps is the frame boundary.
- Output registers (bcd_out, an_n, frame_done are all registered):
  - Edge at the end of a tick cycle: an_n loads all ones (1-cycle dead time, anti-ghosting); bcd_out holds its value.
  - Every other edge: an_n loads ~(1<<idx); bcd_out loads active[idx].
  - After reset release, the first edge drives digit 0.
  - Each digit is lit for PRESCALE-1 cycles, then blanked for 1 cycle.
- frame_done is registered high for exactly one cycle following the frame-boundary tick.
- Load and double buffer:
  - load=1: shadow <= digits_in, pending <= 1.
  - Frame boundary with pending=1: active <= shadow, pending <= 0. The new values appear starting at the next lit slot of digit 0.
  - Frame boundary with pending=0: active unchanged.
  - load and frame boundary in the same cycle: active <= old shadow if pending was 1. shadow <= digits_in, pending stays 1, and the new data shows one frame later.
  - Back-to-back loads before a boundary: the last load wins; earlier values are never displayed.
- Width and validity:
  - Nibbles above 9 pass through unchanged; the decoder's behaviour for them is not this block's concern.
  - digits_in is sampled only when load=1.
- Reset mid-scan: all state returns to reset values immediately; any pending load is discarded.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - At each frame boundary, the block computes a blank mask from the newly active buffer: every digit above the most significant nonzero digit is blanked.
  - Digit 0 is never blanked.
  - In lit slots of blanked digits, an_n stays all ones; bcd_out still carries the value.
  - Mask reset value is 0 (nothing blanked).
- Not defined: all digits are always lit in their slots; no mask logic is synthesised.

Test Plan:
1. Reset, then scan with no load (NDIG=4, PRESCALE=4) -> each digit slot lasts 4 cycles: 3 cycles lit, 1 cycle all-high. an_n lit pattern sequence is 1110, 1101, 1011, 0111. bcd_out=0 throughout. frame_done pulses once every 16 cycles.
2. load digits_in=16'h1234 mid-frame -> pending=1 until the boundary. Next frame shows 4, 3, 2, 1 on digits 0..3. pending=0 after the boundary.
3. Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 is ever displayed; 1111 never appears on bcd_out.
4. load 16'h5678 in the exact frame-boundary cycle while 16'h1234 is pending -> next frame shows 1234; the following frame shows 5678.
5. Assert rst mid-slot with pending=1 -> an_n goes all ones and bcd_out=0 asynchronously, pending=0. After release, the scan restarts at digit 0 showing 0s.
6. LEADING_ZERO_BLANK_EN defined, load 16'h0070 -> digits 3 and 2 stay dark (an_n all ones in their slots). Digits 1 and 0 light with 7 and 0. load 16'h0000 -> only digit 0 lights.
